fetch_seq: RTL and testbench
============================

FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 SHALL provide parameter PC_W, default 8, the program counter width in bits (the instruction ROM address width).
REQ-002 SHALL provide parameter INSTR_W, default 9, the instruction word width.
REQ-003 SHALL provide parameter HALT_WORD, default 9'b000000000, the instruction encoding that terminates a program.
REQ-004 SHALL provide parameter RS_DEPTH, default 4, the number of return-stack entries.
REQ-005 SHALL have a single clock and a synchronous, active-high reset, with ports as follows:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that starts or restarts the program at address 0.
- stall  in  1  holds the pc and suppresses instr_valid.
- branch_taken  in  1  absolute jump request.
- branch_target  in  PC_W  jump destination.
- call  in  1  push pc+1, then jump to branch_target (RETURN_STACK_EN only).
- ret  in  1  pop into pc (RETURN_STACK_EN only).
- instruction  in  INSTR_W  ROM data for the current pc (combinational ROM).
- pc  out  PC_W  instruction ROM address (registered).
- instr_valid  out  1  instruction is consumed this cycle.
- done  out  1  sticky halt flag.
- rs_err  out  1  sticky return-stack overflow/underflow flag.

Function
REQ-006 SHALL implement the states IDLE, RUN and HALT in a registered FSM.
REQ-007 In IDLE, pc SHALL hold; when start=1 the block SHALL load pc=0, clear done and rs_err, and enter RUN on the next edge.
REQ-008 instr_valid SHALL equal (state==RUN && !stall), driven combinationally from the registered state.
REQ-009 In RUN, the next-pc priority SHALL be: stall (hold) > instruction==HALT_WORD (hold, go to HALT) > call > ret > branch_taken (pc=branch_target) > pc+1.
REQ-010 pc+1 SHALL wrap modulo 2^PC_W (255 -> 0 with the default width), with no flag raised.
REQ-011 The HALT_WORD check SHALL be ignored while stall=1, and the instruction SHALL be re-evaluated when the stall is released.
REQ-012 On entering HALT, done SHALL rise on the same edge and stay high until start or reset; pc SHALL hold at the halt address.
REQ-013 A start pulse while in HALT SHALL behave as a start from IDLE; a start pulse while in RUN SHALL be ignored.
REQ-014 branch_taken, call and ret SHALL be ignored outside RUN and while stall=1.
REQ-015 The return stack, when present, SHALL be a LIFO of RS_DEPTH entries with a count register.
REQ-016 A push when the stack is full SHALL set rs_err, discard the push, and still jump.
REQ-017 A pop when the stack is empty SHALL set rs_err and advance pc by 1.
REQ-018 If call and ret are asserted in the same cycle, call SHALL win and ret SHALL be dropped.

Reset
REQ-019 reset SHALL dominate all inputs and SHALL force state=IDLE, pc=0, done=0, rs_err=0 and stack count=0 on the next edge.
REQ-020 reset asserted mid-RUN SHALL take effect on the next edge; no partial fetch SHALL be preserved.

Configuration
REQ-021 The macro FETCH_SEQ_RETURN_STACK_EN SHALL compile the return stack in or out.
- Defined: call and ret behave per REQ-009 and REQ-015 to REQ-018.
- Undefined: call and ret are ignored, no stack storage is built, and rs_err is tied to 0.

Verification
REQ-022 Scenario: reset, then a start pulse with the ROM returning a non-halt word -> pc steps 0,1,2,... with instr_valid=1 each cycle.
REQ-023 Scenario: ROM returns HALT_WORD at pc=88 -> pc holds at 88, done=1 the cycle after, instr_valid=0; a subsequent start -> pc=0 and done=0.
REQ-024 Scenario: stall held for 3 cycles at pc=4 -> pc=4 and instr_valid=0 throughout; after release, pc=5.
REQ-025 Scenario: branch_taken=1 with branch_target=57 at pc=10 -> pc=57 on the next edge; pc=255 with no branch -> pc=0 on the next edge.
REQ-026 Scenario (FETCH_SEQ_RETURN_STACK_EN defined): call to 87 from pc=20 -> pc=87; ret -> pc=21; five nested calls -> rs_err=1; ret on an empty stack -> rs_err=1 and pc+1.
REQ-027 Scenario: reset asserted during RUN at pc=40 -> pc=0, state=IDLE and done=0 on the next edge.

Source files
------------

// File: rtl/fetch_seq.sv
// fetch_seq: instruction fetch sequencer driving a combinational instruction ROM.
// Steps the pc, honours stall, absolute branches and a halt encoding, and
// optionally provides a call/return stack.
// Build option: define FETCH_SEQ_RETURN_STACK_EN to include the return stack;
// without it, call and ret are ignored and rs_err is constant 0.
//
// state | meaning
// IDLE  | waiting for start, pc held
// RUN   | fetching, one instruction per non-stalled cycle
// HALT  | halt word seen, pc held at its address, done high
module fetch_seq #(
   parameter int                 PC_W      = 8,
   parameter int                 INSTR_W   = 9,
   parameter logic [INSTR_W-1:0] HALT_WORD = '0,
   parameter int                 RS_DEPTH  = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [PC_W-1:0]    branch_target,
   input  logic               call,
   input  logic               ret,
   input  logic [INSTR_W-1:0] instruction,
   output logic [PC_W-1:0]    pc,
   output logic               instr_valid,
   output logic               done,
   output logic               rs_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t          state;
   logic [PC_W-1:0] pc_inc;
   logic            is_halt;

   // Wraps modulo 2^PC_W by construction.
   assign pc_inc  = pc + 1'b1;
   assign is_halt = (instruction == HALT_WORD);

   // An instruction is consumed on every running, non-stalled cycle.
   assign instr_valid = (state == ST_RUN) && !stall;

`ifdef FETCH_SEQ_RETURN_STACK_EN
   localparam int CNT_W = $clog2(RS_DEPTH + 1);
   localparam int PTR_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

   logic [PC_W-1:0]  rs_mem [RS_DEPTH];
   logic [CNT_W-1:0] rs_cnt;
   logic             rs_err_q;
   logic             rs_full;
   logic             rs_empty;
   logic             rs_push;
   logic [PTR_W-1:0] rs_wr_idx;
   logic [PTR_W-1:0] rs_top_idx;
   logic [PC_W-1:0]  rs_top;

   assign rs_full    = (rs_cnt == CNT_W'(RS_DEPTH));
   assign rs_empty   = (rs_cnt == '0);
   assign rs_wr_idx  = PTR_W'(rs_cnt);
   assign rs_top_idx = PTR_W'(rs_cnt - 1'b1);
   assign rs_top     = rs_mem[rs_top_idx];
   assign rs_err     = rs_err_q;

   // A push happens only for a call that wins arbitration and finds room.
   assign rs_push = !reset && (state == ST_RUN) && !stall && !is_halt && call && !rs_full;

   // Stack storage carries no reset; the count register defines validity.
   always_ff @(posedge clk) begin
      if (rs_push) begin
         rs_mem[rs_wr_idx] <= pc_inc;
      end
   end
`else
   logic unused_rs_in;

   assign unused_rs_in = call ^ ret;
   assign rs_err       = 1'b0;
`endif

   // Sequencer: state, pc, sticky flags and stack count.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         pc    <= '0;
         done  <= 1'b0;
`ifdef FETCH_SEQ_RETURN_STACK_EN
         rs_cnt   <= '0;
         rs_err_q <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE, ST_HALT: begin
               if (start) begin
                  state <= ST_RUN;
                  pc    <= '0;
                  done  <= 1'b0;
`ifdef FETCH_SEQ_RETURN_STACK_EN
                  // A fresh program starts with an empty stack.
                  rs_cnt   <= '0;
                  rs_err_q <= 1'b0;
`endif
               end
            end
            ST_RUN: begin
               if (!stall) begin
                  if (is_halt) begin
                     state <= ST_HALT;
                     done  <= 1'b1;
                  end
`ifdef FETCH_SEQ_RETURN_STACK_EN
                  else if (call) begin
                     pc <= branch_target;
                     if (rs_full) begin
                        rs_err_q <= 1'b1;
                     end else begin
                        rs_cnt <= rs_cnt + 1'b1;
                     end
                  end else if (ret) begin
                     if (rs_empty) begin
                        rs_err_q <= 1'b1;
                        pc       <= pc_inc;
                     end else begin
                        pc     <= rs_top;
                        rs_cnt <= rs_cnt - 1'b1;
                     end
                  end
`endif
                  else if (branch_taken) begin
                     pc <= branch_target;
                  end else begin
                     pc <= pc_inc;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: reset, sequential fetch, stall, branch, wrap,
// halt/restart, return stack (when built in) and mid-run reset.
module tb_fetch_seq;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       stall;
   logic       branch_taken;
   logic [7:0] branch_target;
   logic       call;
   logic       ret;
   logic [8:0] instruction;
   logic [7:0] pc;
   logic       instr_valid;
   logic       done;
   logic       rs_err;

   logic       halt_en;
   logic [7:0] halt_pc;

   int n_checks = 0;
   int n_err    = 0;

   fetch_seq dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .call          (call),
      .ret           (ret),
      .instruction   (instruction),
      .pc            (pc),
      .instr_valid   (instr_valid),
      .done          (done),
      .rs_err        (rs_err)
   );

   always #5 clk = ~clk;

   // Combinational ROM: halt word at halt_pc when enabled, otherwise a non-halt word.
   always_comb begin
      instruction = 9'h1A5;
      if (halt_en && (pc == halt_pc)) instruction = 9'h000;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_branch(input logic [7:0] tgt);
      branch_taken  = 1'b1;
      branch_target = tgt;
      tick();
      branch_taken  = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
      branch_target = 8'd0; call = 1'b0; ret = 1'b0;
      halt_en = 1'b0; halt_pc = 8'd88;
      tick();
      tick();
      reset = 1'b0;
      check("reset_pc", 32'(pc), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_valid", 32'(instr_valid), 32'd0);
      check("reset_rs_err", 32'(rs_err), 32'd0);

      // Idle holds without start.
      tick();
      check("idle_pc", 32'(pc), 32'd0);
      check("idle_valid", 32'(instr_valid), 32'd0);

      // Start and sequential fetch.
      start = 1'b1;
      tick();
      start = 1'b0;
      check("run_pc0", 32'(pc), 32'd0);
      check("run_valid0", 32'(instr_valid), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         tick();
         check("run_pc_seq", 32'(pc), 32'(i));
         check("run_valid_seq", 32'(instr_valid), 32'd1);
      end

      // Stall for 3 cycles at pc=4.
      stall = 1'b1;
      #1;
      check("stall_valid_now", 32'(instr_valid), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_pc", 32'(pc), 32'd4);
         check("stall_valid", 32'(instr_valid), 32'd0);
      end
      stall = 1'b0;
      #1;
      check("unstall_valid", 32'(instr_valid), 32'd1);
      tick();
      check("unstall_pc", 32'(pc), 32'd5);

      // Advance to pc=10, then branch to 57.
      for (int i = 0; i < 5; i++) tick();
      check("pre_branch_pc", 32'(pc), 32'd10);
      do_branch(8'd57);
      check("branch_pc", 32'(pc), 32'd57);

      // Branch ignored while stalled.
      stall = 1'b1;
      do_branch(8'd3);
      stall = 1'b0;
      check("branch_stalled_pc", 32'(pc), 32'd57);

      // Wrap 255 -> 0.
      do_branch(8'd254);
      check("branch_254", 32'(pc), 32'd254);
      tick();
      check("pc_255", 32'(pc), 32'd255);
      tick();
      check("wrap_pc", 32'(pc), 32'd0);
      check("wrap_done", 32'(done), 32'd0);

`ifdef FETCH_SEQ_RETURN_STACK_EN
      do_branch(8'd20);
      check("pre_call_pc", 32'(pc), 32'd20);
      call = 1'b1; branch_target = 8'd87;
      tick();
      call = 1'b0;
      check("call_pc", 32'(pc), 32'd87);
      ret = 1'b1;
      tick();
      ret = 1'b0;
      check("ret_pc", 32'(pc), 32'd21);
      check("ret_rs_err", 32'(rs_err), 32'd0);
      // Four pushes fill the stack: 22, 101, 111, 121.
      for (int k = 0; k < 4; k++) begin
         call = 1'b1; branch_target = 8'(100 + 10 * k);
         tick();
      end
      check("full_pc", 32'(pc), 32'd130);
      check("full_rs_err", 32'(rs_err), 32'd0);
      branch_target = 8'd140;
      tick();
      call = 1'b0;
      check("ovf_pc", 32'(pc), 32'd140);
      check("ovf_rs_err", 32'(rs_err), 32'd1);
      ret = 1'b1;
      tick();
      check("pop1_pc", 32'(pc), 32'd121);
      tick();
      check("pop2_pc", 32'(pc), 32'd111);
      tick();
      check("pop3_pc", 32'(pc), 32'd101);
      tick();
      check("pop4_pc", 32'(pc), 32'd22);
      // call and ret together: call wins, pushes 23.
      call = 1'b1; branch_target = 8'd60;
      tick();
      call = 1'b0;
      check("callret_pc", 32'(pc), 32'd60);
      tick();
      ret = 1'b0;
      check("callret_pop_pc", 32'(pc), 32'd23);
`else
      call = 1'b1; branch_target = 8'd99;
      tick();
      call = 1'b0;
      check("call_ignored_pc", 32'(pc), 32'd1);
      ret = 1'b1;
      tick();
      ret = 1'b0;
      check("ret_ignored_pc", 32'(pc), 32'd2);
      check("rs_err_tied", 32'(rs_err), 32'd0);
`endif

      // Halt at 88, first while stalled (ignored), then on release.
      halt_en = 1'b1;
      do_branch(8'd88);
      check("at_halt_pc", 32'(pc), 32'd88);
      check("at_halt_valid", 32'(instr_valid), 32'd1);
      stall = 1'b1;
      tick();
      check("halt_stalled_done", 32'(done), 32'd0);
      check("halt_stalled_pc", 32'(pc), 32'd88);
      stall = 1'b0;
      tick();
      check("halt_done", 32'(done), 32'd1);
      check("halt_pc", 32'(pc), 32'd88);
      check("halt_valid", 32'(instr_valid), 32'd0);
      do_branch(8'd5);
      check("halt_hold_pc", 32'(pc), 32'd88);
      check("halt_hold_done", 32'(done), 32'd1);
      halt_en = 1'b0;

      // Restart from HALT.
      start = 1'b1;
      tick();
      start = 1'b0;
      check("restart_pc", 32'(pc), 32'd0);
      check("restart_done", 32'(done), 32'd0);
      check("restart_valid", 32'(instr_valid), 32'd1);
`ifdef FETCH_SEQ_RETURN_STACK_EN
      check("restart_rs_err", 32'(rs_err), 32'd0);
      ret = 1'b1;
      tick();
      ret = 1'b0;
      check("udf_pc", 32'(pc), 32'd1);
      check("udf_rs_err", 32'(rs_err), 32'd1);
`endif

      // Start while running is ignored.
      do_branch(8'd30);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_in_run_pc", 32'(pc), 32'd31);

      // Reset mid-run at pc=40.
      do_branch(8'd40);
      check("pre_reset_pc", 32'(pc), 32'd40);
      reset = 1'b1;
      tick();
      check("midrst_pc", 32'(pc), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_valid", 32'(instr_valid), 32'd0);
      check("midrst_rs_err", 32'(rs_err), 32'd0);
      // Reset dominates start.
      start = 1'b1;
      tick();
      start = 1'b0;
      reset = 1'b0;
      check("rst_dom_valid", 32'(instr_valid), 32'd0);
      tick();
      check("idle_after_rst_pc", 32'(pc), 32'd0);
      check("idle_after_rst_valid", 32'(instr_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
